// File: rtl/apb_st_reg_slave.sv
// APB completer: NUM_REGS-1 byte-strobed read/write data registers plus a
// read-only 32-bit completed-transfer counter at the last slot, with fixed wait states.
module apb_st_reg_slave #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned NDATA  = NUM_REGS - 1;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned CNT_W  = 32;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_IDX  = ADDR_WIDTH'(NDATA);
  localparam logic [WAIT_W-1:0]     WAIT_END = WAIT_W'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                  state_q, state_d, phase_c;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0]   regs_q [NDATA];
  logic [DATA_WIDTH-1:0]   regs_d [NDATA];
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0]   idx_c;
  logic                    misalign_c;
  logic                    out_of_range_c;
  logic                    ro_write_c;
  logic                    err_c;
  logic                    pready_c;
  logic                    done_c;
  logic [DATA_WIDTH-1:0]   rdata_c;

  // Address decode and error classification
  always_comb begin
    idx_c          = paddr >> OFF_W;
    misalign_c     = (paddr & OFF_MASK) != '0;
    out_of_range_c = 32'(idx_c) >= NUM_REGS;
    ro_write_c     = pwrite && (idx_c == CNT_IDX);
    err_c          = misalign_c || out_of_range_c || ro_write_c;
  end

  // Setup is recognised in the cycle the master presents it, so that the
  // access phase (and a zero-wait completion) lands on the very next cycle.
  always_comb begin
    phase_c = state_q;
    if (state_q == IDLE && psel && !penable) begin
      phase_c = SETUP;
    end
  end

  assign pready_c = (state_q == ACCESS) && (wait_cnt_q == WAIT_END);
  assign done_c   = pready_c && psel;

  // Next-state and wait counter
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    case (phase_c)
      IDLE: begin
        state_d = IDLE;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (pready_c) begin
          // A back-to-back setup is picked up from IDLE in the following cycle
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register write with byte strobes; error writes change nothing
  always_comb begin
    regs_d = regs_q;
    if (done_c && pwrite && !err_c) begin
      for (int i = 0; i < int'(NDATA); i++) begin
        if (idx_c == ADDR_WIDTH'(i)) begin
          for (int b = 0; b < int'(STRB_W); b++) begin
            if (pstrb[b]) begin
              regs_d[i][8*b +: 8] = pwdata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  assign cnt_d = cnt_q + CNT_W'(done_c);

  // Read mux; the counter slot returns its pre-increment value
  always_comb begin
    rdata_c = '0;
    if (idx_c == CNT_IDX) begin
      rdata_c = DATA_WIDTH'(cnt_q);
    end else begin
      for (int i = 0; i < int'(NDATA); i++) begin
        if (idx_c == ADDR_WIDTH'(i)) begin
          rdata_c = regs_q[i];
        end
      end
    end
  end

  assign pready  = pready_c;
  assign pslverr = pready_c && err_c;
  assign prdata  = (pready_c && !pwrite && !err_c) ? rdata_c : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < int'(NDATA); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cnt_q      <= cnt_d;
      regs_q     <= regs_d;
    end
  end

endmodule

// File: tb/tb_apb_st_reg_slave.sv
// Directed bench: a zero-wait and a three-wait instance of apb_st_reg_slave
// on shared bus wires with separate selects.
module tb_apb_st_reg_slave;

  logic        clk;
  logic        reset;
  logic        psel0, psel1;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1;
  logic        pslverr0, pslverr1;

  int n_cmp = 0;
  int n_bad = 0;

  apb_st_reg_slave #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb_st_reg_slave #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller is #1 after a rising edge; returns #1 after the completing edge
  // with the bus idle, so consecutive calls are back-to-back.
  task automatic xfer(input bit tgt, input bit wr, input logic [7:0] addr,
                      input logic [31:0] wd, input logic [3:0] sb,
                      output logic [31:0] rd, output logic er, output int cyc);
    bit done;
    done = 1'b0;
    rd   = '0;
    er   = 1'b0;
    cyc  = 1;
    if (tgt) psel1 = 1'b1; else psel0 = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    pstrb   = sb;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc     = 2;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (tgt ? pready1 : pready0) begin
        done = 1'b1;
        rd   = tgt ? prdata1 : prdata0;
        er   = tgt ? pslverr1 : pslverr0;
      end
      @(posedge clk); #1;
      if (!done) cyc++;
    end
    psel0   = 1'b0;
    psel1   = 1'b0;
    penable = 1'b0;
    if (!done) chk("pready_timeout", 32'(tgt ? pready1 : pready0), 32'd1);
  endtask

  task automatic wr_chk(input bit tgt, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] sb, input logic exp_err, input string tag);
    logic [31:0] rd;
    logic        er;
    int          cyc;
    xfer(tgt, 1'b1, addr, wd, sb, rd, er, cyc);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
    chk({tag, "_cyc"}, 32'(cyc), tgt ? 32'd5 : 32'd2);
  endtask

  task automatic rd_chk(input bit tgt, input logic [7:0] addr, input logic [31:0] exp_data,
                        input logic exp_err, input string tag);
    logic [31:0] rd;
    logic        er;
    int          cyc;
    xfer(tgt, 1'b0, addr, 32'h0, 4'h0, rd, er, cyc);
    chk({tag, "_data"}, rd, exp_data);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
    chk({tag, "_cyc"}, 32'(cyc), tgt ? 32'd5 : 32'd2);
  endtask

  initial begin
    reset   = 1'b1;
    psel0   = 1'b0;
    psel1   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;

    // Outputs quiet while reset is held
    repeat (2) @(negedge clk);
    chk("rst_pready0", 32'(pready0), 32'd0);
    chk("rst_pslverr0", 32'(pslverr0), 32'd0);
    chk("rst_prdata0", prdata0, 32'h0);
    chk("rst_pready1", 32'(pready1), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic write/read on the zero-wait slave; counter after 2 transfers
    wr_chk(1'b0, 8'h04, 32'hDEADBEEF, 4'hF, 1'b0, "w04");
    rd_chk(1'b0, 8'h04, 32'hDEADBEEF, 1'b0, "r04");
    rd_chk(1'b0, 8'h3C, 32'd2, 1'b0, "cnt_a");

    // Byte strobes and the empty-strobe no-op
    wr_chk(1'b0, 8'h08, 32'h11223344, 4'hF, 1'b0, "w08_full");
    wr_chk(1'b0, 8'h08, 32'hAABBCCDD, 4'h5, 1'b0, "w08_strb5");
    rd_chk(1'b0, 8'h08, 32'h11BB33DD, 1'b0, "r08_strb5");
    wr_chk(1'b0, 8'h08, 32'hFFFFFFFF, 4'h0, 1'b0, "w08_strb0");
    rd_chk(1'b0, 8'h08, 32'h11BB33DD, 1'b0, "r08_strb0");

    // Error responses leave registers alone but still count
    rd_chk(1'b0, 8'h02, 32'h0, 1'b1, "r02_misal");
    wr_chk(1'b0, 8'h40, 32'h12345678, 4'hF, 1'b1, "w40_oor");
    wr_chk(1'b0, 8'h3C, 32'h12345678, 4'hF, 1'b1, "w3C_ro");
    wr_chk(1'b0, 8'h05, 32'h00000000, 4'hF, 1'b1, "w05_misal");
    rd_chk(1'b0, 8'h04, 32'hDEADBEEF, 1'b0, "r04_after_err");
    rd_chk(1'b0, 8'h08, 32'h11BB33DD, 1'b0, "r08_after_err");
    rd_chk(1'b0, 8'h3C, 32'd14, 1'b0, "cnt_b");

    // Last writable slot
    wr_chk(1'b0, 8'h38, 32'h0BADF00D, 4'hF, 1'b0, "w38");
    rd_chk(1'b0, 8'h38, 32'h0BADF00D, 1'b0, "r38");
    rd_chk(1'b0, 8'h3C, 32'd17, 1'b0, "cnt_c");

    // Counter wrap
    force u_ws0.cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release u_ws0.cnt_q;
    @(posedge clk); #1;
    rd_chk(1'b0, 8'h3C, 32'hFFFF_FFFF, 1'b0, "cnt_max");
    rd_chk(1'b0, 8'h3C, 32'h0, 1'b0, "cnt_wrap");

    // Three wait states: 5-cycle transfers, back-to-back write then read
    wr_chk(1'b1, 8'h10, 32'hCAFEF00D, 4'hF, 1'b0, "ws3_w10");
    rd_chk(1'b1, 8'h10, 32'hCAFEF00D, 1'b0, "ws3_r10");
    rd_chk(1'b1, 8'h3C, 32'd2, 1'b0, "ws3_cnt_a");

    // Abort: psel dropped in the second wait cycle
    psel1   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h14;
    pwdata  = 32'h55AA55AA;
    pstrb   = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("abort_wait1_pready", 32'(pready1), 32'd0);
    @(posedge clk); #1;
    psel1   = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    chk("abort_pready", 32'(pready1), 32'd0);
    @(posedge clk); #1;
    rd_chk(1'b1, 8'h14, 32'h0, 1'b0, "ws3_r14_abort");
    rd_chk(1'b1, 8'h3C, 32'd4, 1'b0, "ws3_cnt_b");

    // Reset asserted in the completing cycle: pready drops, no write
    psel0   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h1C;
    pwdata  = 32'h77777777;
    pstrb   = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("pre_rst_pready", 32'(pready0), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_pready", 32'(pready0), 32'd0);
    chk("mid_rst_pslverr", 32'(pslverr0), 32'd0);
    @(posedge clk); #1;
    psel0   = 1'b0;
    penable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    rd_chk(1'b0, 8'h1C, 32'h0, 1'b0, "r1C_after_rst");
    rd_chk(1'b0, 8'h04, 32'h0, 1'b0, "r04_after_rst");
    rd_chk(1'b0, 8'h3C, 32'd2, 1'b0, "cnt_after_rst");
    rd_chk(1'b1, 8'h10, 32'h0, 1'b0, "ws3_r10_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
